// File: rtl/gf_alu_seq_if.sv
// Command/result handshake bundle for the sequential GF(2^M) ALU.
// The unit side uses the slave modport; the command source/consumer uses master.
interface gf_alu_seq_if #(
    parameter int M_C = 8
);
    logic           ing_valid;
    logic           ing_ready;
    logic [1:0]     ing_op;
    logic [M_C-1:0] ing_a;
    logic [M_C-1:0] ing_b;
    logic           egr_valid;
    logic           egr_ready;
    logic [M_C-1:0] egr_result;
    logic           egr_error;

    modport master (
        output ing_valid, ing_op, ing_a, ing_b, egr_ready,
        input  ing_ready, egr_valid, egr_result, egr_error
    );

    modport slave (
        input  ing_valid, ing_op, ing_a, ing_b, egr_ready,
        output ing_ready, egr_valid, egr_result, egr_error
    );
endinterface

// File: rtl/gf_alu_seq.sv
// Sequential GF(2^M) add/mul/div unit built around one bit-serial MSB-first multiplier.
// Division multiplies a by b^(2^M-2), formed by M-1 square-and-accumulate rounds.
module gf_alu_seq #(
    parameter int             M_C    = 8,
    parameter logic [M_C:0]   POLY_C = 9'h11D
) (
    input  logic              clk,
    input  logic              rst,
    gf_alu_seq_if.slave       bus,
    output logic              busy
);
    localparam int             CW     = (M_C > 2) ? $clog2(M_C) : 1;
    localparam logic [CW-1:0]  LAST_C = CW'(M_C - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MUL     = 3'd1,
        S_INV_SQ  = 3'd2,
        S_INV_MUL = 3'd3,
        S_DIV_MUL = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  i_q, i_d;
    logic [M_C-1:0] a_q, a_d;
    logic [M_C-1:0] b_q, b_d;
    logic [M_C-1:0] sq_q, sq_d;
    logic [M_C-1:0] acc_q, acc_d;
    logic [M_C-1:0] p_q, p_d;
    logic [M_C-1:0] result_q, result_d;
    logic           error_q, error_d;

    logic [M_C-1:0] mplier_s;
    logic [M_C-1:0] mcand_s;
    logic [CW-1:0]  idx_s;
    logic [M_C-1:0] p_next_s;
    logic           pass_end_s;

    // One shift-and-add step: shift p left, fold bit M back through the polynomial, add partial product.
    function automatic logic [M_C-1:0] gf_step(input logic [M_C-1:0] p,
                                               input logic [M_C-1:0] mcand,
                                               input logic           bit_in);
        logic [M_C:0] sh;
        sh = {p, 1'b0};
        if (sh[M_C]) begin
            sh = sh ^ POLY_C;
        end else begin
            sh = sh;
        end
        return sh[M_C-1:0] ^ (bit_in ? mcand : {M_C{1'b0}});
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CW{1'b0}};
            i_q      <= {CW{1'b0}};
            a_q      <= {M_C{1'b0}};
            b_q      <= {M_C{1'b0}};
            sq_q     <= {M_C{1'b0}};
            acc_q    <= {M_C{1'b0}};
            p_q      <= {M_C{1'b0}};
            result_q <= {M_C{1'b0}};
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            i_q      <= i_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sq_q     <= sq_d;
            acc_q    <= acc_d;
            p_q      <= p_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

    // Operand routing into the shared core and next-state/datapath decisions.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        i_d      = i_q;
        a_d      = a_q;
        b_d      = b_q;
        sq_d     = sq_q;
        acc_d    = acc_q;
        p_d      = p_q;
        result_d = result_q;
        error_d  = error_q;

        case (state_q)
            S_INV_SQ: begin
                mplier_s = sq_q;
                mcand_s  = sq_q;
            end
            S_INV_MUL: begin
                mplier_s = acc_q;
                mcand_s  = sq_q;
            end
            S_DIV_MUL: begin
                mplier_s = a_q;
                mcand_s  = acc_q;
            end
            default: begin
                mplier_s = a_q;
                mcand_s  = b_q;
            end
        endcase

        idx_s      = LAST_C - cnt_q;
        p_next_s   = gf_step(p_q, mcand_s, mplier_s[idx_s]);
        pass_end_s = (cnt_q == LAST_C);

        case (state_q)
            S_IDLE: begin
                if (bus.ing_valid) begin
                    a_d   = bus.ing_a;
                    b_d   = bus.ing_b;
                    cnt_d = {CW{1'b0}};
                    p_d   = {M_C{1'b0}};
                    case (bus.ing_op)
                        2'b00: begin
                            result_d = bus.ing_a ^ bus.ing_b;
                            error_d  = 1'b0;
                            state_d  = S_DONE;
                        end
                        2'b01: begin
                            state_d = S_MUL;
                        end
                        2'b10: begin
                            if (bus.ing_b == {M_C{1'b0}}) begin
                                result_d = {M_C{1'b0}};
                                error_d  = 1'b1;
                                state_d  = S_DONE;
                            end else begin
                                sq_d    = bus.ing_b;
                                acc_d   = {{(M_C-1){1'b0}}, 1'b1};
                                i_d     = {{(CW-1){1'b0}}, 1'b1};
                                state_d = S_INV_SQ;
                            end
                        end
                        default: begin
                            result_d = {M_C{1'b0}};
                            error_d  = 1'b1;
                            state_d  = S_DONE;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL, S_INV_SQ, S_INV_MUL, S_DIV_MUL: begin
                if (pass_end_s) begin
                    cnt_d = {CW{1'b0}};
                    p_d   = {M_C{1'b0}};
                    case (state_q)
                        S_INV_SQ: begin
                            sq_d    = p_next_s;
                            state_d = S_INV_MUL;
                        end
                        S_INV_MUL: begin
                            acc_d = p_next_s;
                            if (i_q == LAST_C) begin
                                state_d = S_DIV_MUL;
                            end else begin
                                i_d     = i_q + {{(CW-1){1'b0}}, 1'b1};
                                state_d = S_INV_SQ;
                            end
                        end
                        default: begin
                            result_d = p_next_s;
                            error_d  = 1'b0;
                            state_d  = S_DONE;
                        end
                    endcase
                end else begin
                    p_d   = p_next_s;
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                if (bus.egr_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.ing_ready  = (state_q == S_IDLE);
    assign bus.egr_valid  = (state_q == S_DONE);
    assign bus.egr_result = result_q;
    assign bus.egr_error  = error_q;
    assign busy           = (state_q != S_IDLE);
endmodule

// File: tb/tb_gf_alu_seq.sv
// Scoreboard bench for gf_alu_seq: an 8-bit (0x11D) instance and a 4-bit (0x13) instance.
// Expected results come from a carry-less multiply reference and a brute-force quotient search.
module tb_gf_alu_seq;
    logic clk;
    logic rst;
    logic busy8;
    logic busy4;

    gf_alu_seq_if #(.M_C(8)) bus8 ();
    gf_alu_seq_if #(.M_C(4)) bus4 ();

    gf_alu_seq #(.M_C(8), .POLY_C(9'h11D)) dut8 (.clk(clk), .rst(rst), .bus(bus8), .busy(busy8));
    gf_alu_seq #(.M_C(4), .POLY_C(5'h13))  dut4 (.clk(clk), .rst(rst), .bus(bus4), .busy(busy4));

    typedef struct {
        int res;
        int err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int gf_mul_ref(input int m, input int poly, input int a, input int b);
        int prod;
        prod = 0;
        for (int k = 0; k < m; k++) begin
            if (((b >> k) & 1) == 1) prod = prod ^ (a << k);
        end
        for (int k = 2 * m - 2; k >= m; k--) begin
            if (((prod >> k) & 1) == 1) prod = prod ^ (poly << (k - m));
        end
        return prod;
    endfunction

    function automatic int gf_div_ref(input int m, input int poly, input int a, input int b);
        for (int x = 0; x < (1 << m); x++) begin
            if (gf_mul_ref(m, poly, x, b) == a) return x;
        end
        return -1;
    endfunction

    task automatic sb_compare(input string tag, input int res, input int err);
        exp_t e;
        check_eq({tag, "_sb_nonempty"}, int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq({tag, "_result"}, res, e.res);
            check_eq({tag, "_error"}, err, e.err);
        end
    endtask

    // Drive one command into the 8-bit unit, measure latency, compare via scoreboard.
    task automatic run8(input string tag, input logic [1:0] op, input int a, input int b,
                        input int exp_res, input int exp_err, input int exp_lat, input bit chk_busy);
        exp_t e;
        int   lat;
        int   busy_ok;
        e.res = exp_res;
        e.err = exp_err;
        sb_q.push_back(e);
        bus8.ing_op    = op;
        bus8.ing_a     = a[7:0];
        bus8.ing_b     = b[7:0];
        bus8.ing_valid = 1'b1;
        check_eq({tag, "_ing_ready"}, int'(bus8.ing_ready), 1);
        @(posedge clk); #1;
        bus8.ing_valid = 1'b0;
        bus8.ing_a     = 8'($urandom);
        bus8.ing_b     = 8'($urandom);
        bus8.ing_op    = 2'($urandom);
        lat = 1;
        busy_ok = 1;
        while (!bus8.egr_valid && lat < 400) begin
            if (!busy8) busy_ok = 0;
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_valid_seen"}, int'(bus8.egr_valid), 1);
        if (exp_lat > 0) check_eq({tag, "_latency"}, lat, exp_lat);
        if (chk_busy) check_eq({tag, "_busy"}, busy_ok, 1);
        sb_compare(tag, int'(bus8.egr_result), int'(bus8.egr_error));
        if (bus8.egr_ready) begin
            @(posedge clk); #1;
            check_eq({tag, "_valid_drop"}, int'(bus8.egr_valid), 0);
            check_eq({tag, "_result_kept"}, int'(bus8.egr_result), exp_res);
        end
    endtask

    // Same flow for the 4-bit unit.
    task automatic run4(input string tag, input logic [1:0] op, input int a, input int b,
                        input int exp_res, input int exp_err, input int exp_lat);
        exp_t e;
        int   lat;
        e.res = exp_res;
        e.err = exp_err;
        sb_q.push_back(e);
        bus4.ing_op    = op;
        bus4.ing_a     = a[3:0];
        bus4.ing_b     = b[3:0];
        bus4.ing_valid = 1'b1;
        check_eq({tag, "_ing_ready"}, int'(bus4.ing_ready), 1);
        @(posedge clk); #1;
        bus4.ing_valid = 1'b0;
        lat = 1;
        while (!bus4.egr_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_valid_seen"}, int'(bus4.egr_valid), 1);
        check_eq({tag, "_latency"}, lat, exp_lat);
        sb_compare(tag, int'(bus4.egr_result), int'(bus4.egr_error));
        @(posedge clk); #1;
        check_eq({tag, "_valid_drop"}, int'(bus4.egr_valid), 0);
    endtask

    task automatic check_reset8(input string tag);
        check_eq({tag, "_ing_ready"}, int'(bus8.ing_ready), 1);
        check_eq({tag, "_egr_valid"}, int'(bus8.egr_valid), 0);
        check_eq({tag, "_egr_result"}, int'(bus8.egr_result), 0);
        check_eq({tag, "_egr_error"}, int'(bus8.egr_error), 0);
        check_eq({tag, "_busy"}, int'(busy8), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a, b, seen;
        rst = 1'b1;
        bus8.ing_valid = 1'b0; bus8.ing_op = 2'b00; bus8.ing_a = 8'd0; bus8.ing_b = 8'd0;
        bus8.egr_ready = 1'b1;
        bus4.ing_valid = 1'b0; bus4.ing_op = 2'b00; bus4.ing_a = 4'd0; bus4.ing_b = 4'd0;
        bus4.egr_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset8("reset8");
        check_eq("reset4_ing_ready", int'(bus4.ing_ready), 1);
        check_eq("reset4_egr_valid", int'(bus4.egr_valid), 0);
        check_eq("reset4_busy", int'(busy4), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run8("add_232_46", 2'b00, 232, 46, 198, 0, 1, 1'b0);
        run8("add_117_0", 2'b00, 117, 0, 117, 0, 1, 1'b0);
        run8("mul_228_214", 2'b01, 228, 214, 88, 0, 9, 1'b1);
        run8("mul_17_151", 2'b01, 17, 151, 18, 0, 9, 1'b1);
        run8("mul_1_218", 2'b01, 1, 218, 218, 0, 9, 1'b1);
        run8("div_29_126", 2'b10, 29, 126, 217, 0, 121, 1'b1);
        run8("div_236_109", 2'b10, 236, 109, 250, 0, 121, 1'b1);
        run8("div_5_0", 2'b10, 5, 0, 0, 1, 1, 1'b0);
        run8("illegal_op", 2'b11, 77, 33, 0, 1, 1, 1'b0);
        run8("add_after_err", 2'b00, 3, 5, 6, 0, 1, 1'b0);

        for (int k = 0; k < 64; k++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            run8("mul_vec", 2'b01, a, b, gf_mul_ref(8, 'h11D, a, b), 0, 9, 1'b0);
        end
        for (int k = 0; k < 64; k++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(1, 255));
            run8("div_vec", 2'b10, a, b, gf_div_ref(8, 'h11D, a, b), 0, 121, 1'b0);
        end

        // Backpressure: result must sit still and new commands must be ignored.
        bus8.egr_ready = 1'b0;
        run8("mul_bp", 2'b01, 200, 99, gf_mul_ref(8, 'h11D, 200, 99), 0, 9, 1'b0);
        bus8.ing_valid = 1'b1;
        bus8.ing_op    = 2'b00;
        bus8.ing_a     = 8'd1;
        bus8.ing_b     = 8'd2;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            check_eq("bp_valid", int'(bus8.egr_valid), 1);
            check_eq("bp_ing_ready", int'(bus8.ing_ready), 0);
            check_eq("bp_result", int'(bus8.egr_result), gf_mul_ref(8, 'h11D, 200, 99));
        end
        bus8.ing_valid = 1'b0;
        bus8.egr_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_release_valid", int'(bus8.egr_valid), 0);
        check_eq("bp_release_ing_ready", int'(bus8.ing_ready), 1);
        check_eq("bp_release_busy", int'(busy8), 0);

        // Reset in the middle of a divide abandons it.
        bus8.ing_op = 2'b10; bus8.ing_a = 8'd29; bus8.ing_b = 8'd126;
        bus8.ing_valid = 1'b1;
        @(posedge clk); #1;
        bus8.ing_valid = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        check_eq("rst_mid_busy_before", int'(busy8), 1);
        rst = 1'b1;
        #1;
        check_reset8("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 130; k++) begin
            @(posedge clk); #1;
            if (bus8.egr_valid) seen = 1;
        end
        check_eq("rst_no_result", seen, 0);
        run8("mul_3_7", 2'b01, 3, 7, 9, 0, 9, 1'b0);

        run4("m4_mul_2_9", 2'b01, 2, 9, 1, 0, 5);
        run4("m4_div_1_2", 2'b10, 1, 2, 9, 0, 29);
        run4("m4_mul_vec", 2'b01, 7, 13, gf_mul_ref(4, 'h13, 7, 13), 0, 5);

        check_eq("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
